// File: rtl/sprite_addr_pipe_pkg.sv
// Shared constants and types for the multi-sprite pixel-address pipeline.
package sprite_addr_pipe_pkg;

   localparam int unsigned CNT_W_DEF  = 10;
   localparam int unsigned ADDR_W_DEF = 17;
   localparam int unsigned SPR_ID_W   = 3;
   localparam int unsigned NFR_W      = 4;

   typedef logic [SPR_ID_W-1:0] spr_id_t;
   typedef logic [NFR_W-1:0]    nfr_t;

   // Divider counter width; a divide-by-one still needs a 1-bit register.
   function automatic int unsigned div_w(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/sprite_addr_pipe_chan.sv
// One sprite channel: frame-tick shadows, animation offset and the S1/S2 address math.
// ADDR_WRAP_EN: wrap out-of-range addresses modulo MEM_DEPTH instead of dropping the hit.
module sprite_addr_pipe_chan
   import sprite_addr_pipe_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned MEM_DEPTH = 76800
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_en_i,
   input  logic              valid_i,
   input  logic              frame_tick_i,
   input  logic              anim_step_i,
   input  logic [CNT_W-1:0]  h_cnt_i,
   input  logic [CNT_W-1:0]  v_cnt_i,
   input  logic              en_i,
   input  logic [CNT_W-1:0]  h_pos_i,
   input  logic [CNT_W-1:0]  v_pos_i,
   input  logic [CNT_W-1:0]  width_i,
   input  logic [CNT_W-1:0]  height_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] stride_i,
   input  nfr_t              nframes_i,
   output logic              hit_o,
   output logic [ADDR_W-1:0] addr_o
);

   localparam int unsigned RAW_W = ADDR_W + CNT_W;

   logic              en_q, en_d;
   logic [CNT_W-1:0]  h_pos_q, h_pos_d, v_pos_q, v_pos_d;
   logic [CNT_W-1:0]  width_q, width_d, height_q, height_d;
   logic [ADDR_W-1:0] base_q, base_d, stride_q, stride_d;
   nfr_t              nframes_q, nframes_d, idx_q, idx_d;
   logic [ADDR_W-1:0] frame_off_q, frame_off_d;

   logic              in_box_q, in_box_d;
   logic [CNT_W-1:0]  dx_q, dx_d, dy_q, dy_d, s1_width_q, s1_width_d;
   logic [RAW_W-1:0]  base_off_q, base_off_d;

   logic              hit_q, hit_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  dx, dy;
   logic [RAW_W-1:0]  raw;

   assign dx  = h_cnt_i - h_pos_q;
   assign dy  = v_cnt_i - v_pos_q;
   assign raw = base_off_q + RAW_W'(dx_q) + RAW_W'(s1_width_q) * RAW_W'(dy_q);

   // Shadows and animation only move on frame_tick; animation follows the settings of the
   // frame that is ending.
   always_comb begin
      en_d        = en_q;
      h_pos_d     = h_pos_q;
      v_pos_d     = v_pos_q;
      width_d     = width_q;
      height_d    = height_q;
      base_d      = base_q;
      stride_d    = stride_q;
      nframes_d   = nframes_q;
      idx_d       = idx_q;
      frame_off_d = frame_off_q;
      if (frame_tick_i) begin
         en_d      = en_i;
         h_pos_d   = h_pos_i;
         v_pos_d   = v_pos_i;
         width_d   = width_i;
         height_d  = height_i;
         base_d    = base_i;
         stride_d  = stride_i;
         nframes_d = nframes_i;
         if (!en_q || nframes_q <= nfr_t'(1)) begin
            idx_d       = '0;
            frame_off_d = '0;
         end else if (anim_step_i) begin
            if (idx_q >= nframes_q - nfr_t'(1)) begin
               idx_d       = '0;
               frame_off_d = '0;
            end else begin
               idx_d       = idx_q + nfr_t'(1);
               frame_off_d = frame_off_q + stride_q;
            end
         end
      end
   end

   always_comb begin
      in_box_d   = in_box_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      s1_width_d = s1_width_q;
      base_off_d = base_off_q;
      hit_d      = hit_q;
      addr_d     = addr_q;
      if (pix_en_i) begin
         in_box_d   = valid_i && en_q && (h_cnt_i >= h_pos_q) && (dx < width_q) &&
                      (v_cnt_i >= v_pos_q) && (dy < height_q);
         dx_d       = dx;
         dy_d       = dy;
         s1_width_d = width_q;
         base_off_d = RAW_W'(base_q) + RAW_W'(frame_off_q);
`ifdef ADDR_WRAP_EN
         hit_d      = in_box_q;
         addr_d     = ADDR_W'(raw % RAW_W'(MEM_DEPTH));
`else
         hit_d      = in_box_q && (raw < RAW_W'(MEM_DEPTH));
         addr_d     = ADDR_W'(raw);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q        <= 1'b0;
         h_pos_q     <= '0;
         v_pos_q     <= '0;
         width_q     <= '0;
         height_q    <= '0;
         base_q      <= '0;
         stride_q    <= '0;
         nframes_q   <= '0;
         idx_q       <= '0;
         frame_off_q <= '0;
         in_box_q    <= 1'b0;
         dx_q        <= '0;
         dy_q        <= '0;
         s1_width_q  <= '0;
         base_off_q  <= '0;
         hit_q       <= 1'b0;
         addr_q      <= '0;
      end else begin
         en_q        <= en_d;
         h_pos_q     <= h_pos_d;
         v_pos_q     <= v_pos_d;
         width_q     <= width_d;
         height_q    <= height_d;
         base_q      <= base_d;
         stride_q    <= stride_d;
         nframes_q   <= nframes_d;
         idx_q       <= idx_d;
         frame_off_q <= frame_off_d;
         in_box_q    <= in_box_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         s1_width_q  <= s1_width_d;
         base_off_q  <= base_off_d;
         hit_q       <= hit_d;
         addr_q      <= addr_d;
      end
   end

   assign hit_o  = hit_q;
   assign addr_o = addr_q;

endmodule

// File: rtl/sprite_addr_pipe.sv
// Multi-sprite pixel-address generator: N channels, frame divider, valid delay and priority mux.
// ADDR_WRAP_EN (in the channel) selects modulo wrap of out-of-range addresses.
module sprite_addr_pipe
   import sprite_addr_pipe_pkg::*;
#(
   parameter int unsigned N_SPR     = 4,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned MEM_DEPTH = 76800,
   parameter int unsigned FRAME_DIV = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pix_en,
   input  logic [CNT_W-1:0]          h_cnt,
   input  logic [CNT_W-1:0]          v_cnt,
   input  logic                      valid_in,
   input  logic                      frame_tick,
   input  logic [N_SPR-1:0]          spr_en,
   input  logic [N_SPR*CNT_W-1:0]    h_pos_f,
   input  logic [N_SPR*CNT_W-1:0]    v_pos_f,
   input  logic [N_SPR*CNT_W-1:0]    width_f,
   input  logic [N_SPR*CNT_W-1:0]    height_f,
   input  logic [N_SPR*ADDR_W-1:0]   base_f,
   input  logic [N_SPR*ADDR_W-1:0]   stride_f,
   input  logic [N_SPR*NFR_W-1:0]    nframes_f,
   output logic [ADDR_W-1:0]         pixel_addr,
   output logic                      hit,
   output logic [SPR_ID_W-1:0]       spr_id,
   output logic                      valid_out
);

   localparam int unsigned DIV_W = div_w(FRAME_DIV);

   logic [DIV_W-1:0]  div_q, div_d;
   logic              anim_step;
   logic [2:0]        vld_q, vld_d;
   logic              hit_q, hit_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   spr_id_t           id_q, id_d;
   logic [N_SPR-1:0]  chan_hit;
   logic [ADDR_W-1:0] chan_addr [N_SPR];

   assign anim_step = frame_tick && (div_q == DIV_W'(FRAME_DIV - 1));

   for (genvar g = 0; g < N_SPR; g++) begin : g_chan
      sprite_addr_pipe_chan #(
         .CNT_W     (CNT_W),
         .ADDR_W    (ADDR_W),
         .MEM_DEPTH (MEM_DEPTH)
      ) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .pix_en_i     (pix_en),
         .valid_i      (valid_in),
         .frame_tick_i (frame_tick),
         .anim_step_i  (anim_step),
         .h_cnt_i      (h_cnt),
         .v_cnt_i      (v_cnt),
         .en_i         (spr_en[g]),
         .h_pos_i      (h_pos_f[g*CNT_W +: CNT_W]),
         .v_pos_i      (v_pos_f[g*CNT_W +: CNT_W]),
         .width_i      (width_f[g*CNT_W +: CNT_W]),
         .height_i     (height_f[g*CNT_W +: CNT_W]),
         .base_i       (base_f[g*ADDR_W +: ADDR_W]),
         .stride_i     (stride_f[g*ADDR_W +: ADDR_W]),
         .nframes_i    (nframes_f[g*NFR_W +: NFR_W]),
         .hit_o        (chan_hit[g]),
         .addr_o       (chan_addr[g])
      );
   end

   always_comb begin
      div_d = div_q;
      if (frame_tick) begin
         div_d = anim_step ? '0 : div_q + DIV_W'(1);
      end
   end

   // Scan from the top so the lowest-index hitting channel is written last and wins.
   always_comb begin
      vld_d  = vld_q;
      hit_d  = hit_q;
      addr_d = addr_q;
      id_d   = id_q;
      if (pix_en) begin
         vld_d  = {vld_q[1:0], valid_in};
         hit_d  = 1'b0;
         addr_d = '0;
         id_d   = '0;
         for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
            if (chan_hit[i]) begin
               hit_d  = 1'b1;
               addr_d = chan_addr[i];
               id_d   = spr_id_t'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         vld_q  <= '0;
         hit_q  <= 1'b0;
         addr_q <= '0;
         id_q   <= '0;
      end else begin
         div_q  <= div_d;
         vld_q  <= vld_d;
         hit_q  <= hit_d;
         addr_q <= addr_d;
         id_q   <= id_d;
      end
   end

   assign pixel_addr = addr_q;
   assign hit        = hit_q;
   assign spr_id     = id_q;
   assign valid_out  = vld_q[2];

endmodule

// File: tb/tb_sprite_addr_pipe.sv
// Bench for sprite_addr_pipe: directed table, multi-cycle corner sequences, random vs. model.
module tb_sprite_addr_pipe;
   import sprite_addr_pipe_pkg::*;

   localparam int unsigned N_SPR     = 4;
   localparam int unsigned CNT_W     = 10;
   localparam int unsigned ADDR_W    = 17;
   localparam int unsigned MEM_DEPTH = 76800;
   localparam int unsigned FRAME_DIV = 2;

   typedef struct packed {
      logic        hit;
      logic [2:0]  id;
      logic [16:0] addr;
      logic        vld;
   } exp_t;

   typedef struct packed {
      int          h;
      int          v;
      logic        vld;
      logic        hit;
      logic [2:0]  id;
      logic [16:0] addr;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pix_en = 1'b0;
   logic valid_in = 1'b0;
   logic frame_tick = 1'b0;
   logic [CNT_W-1:0] h_cnt = '0;
   logic [CNT_W-1:0] v_cnt = '0;
   logic [N_SPR-1:0]        spr_en;
   logic [N_SPR*CNT_W-1:0]  h_pos_f, v_pos_f, width_f, height_f;
   logic [N_SPR*ADDR_W-1:0] base_f, stride_f;
   logic [N_SPR*4-1:0]      nframes_f;
   logic [ADDR_W-1:0]       pixel_addr;
   logic                    hit, valid_out;
   logic [2:0]              spr_id;

   bit cfg_en [N_SPR];
   int cfg_hp [N_SPR], cfg_vp [N_SPR], cfg_w [N_SPR], cfg_h [N_SPR];
   int cfg_base [N_SPR], cfg_stride [N_SPR], cfg_nf [N_SPR];

   bit m_en [N_SPR];
   int m_hp [N_SPR], m_vp [N_SPR], m_w [N_SPR], m_h [N_SPR];
   int m_base [N_SPR], m_stride [N_SPR], m_nf [N_SPR], m_idx [N_SPR];
   int m_ticks;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always_comb begin
      spr_en = '0; h_pos_f = '0; v_pos_f = '0; width_f = '0; height_f = '0;
      base_f = '0; stride_f = '0; nframes_f = '0;
      for (int i = 0; i < N_SPR; i++) begin
         spr_en[i]                   = cfg_en[i];
         h_pos_f[i*CNT_W +: CNT_W]   = CNT_W'(cfg_hp[i]);
         v_pos_f[i*CNT_W +: CNT_W]   = CNT_W'(cfg_vp[i]);
         width_f[i*CNT_W +: CNT_W]   = CNT_W'(cfg_w[i]);
         height_f[i*CNT_W +: CNT_W]  = CNT_W'(cfg_h[i]);
         base_f[i*ADDR_W +: ADDR_W]  = ADDR_W'(cfg_base[i]);
         stride_f[i*ADDR_W +: ADDR_W] = ADDR_W'(cfg_stride[i]);
         nframes_f[i*4 +: 4]         = 4'(cfg_nf[i]);
      end
   end

   sprite_addr_pipe #(
      .N_SPR     (N_SPR),
      .CNT_W     (CNT_W),
      .ADDR_W    (ADDR_W),
      .MEM_DEPTH (MEM_DEPTH),
      .FRAME_DIV (FRAME_DIV)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_en     (pix_en),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .valid_in   (valid_in),
      .frame_tick (frame_tick),
      .spr_en     (spr_en),
      .h_pos_f    (h_pos_f),
      .v_pos_f    (v_pos_f),
      .width_f    (width_f),
      .height_f   (height_f),
      .base_f     (base_f),
      .stride_f   (stride_f),
      .nframes_f  (nframes_f),
      .pixel_addr (pixel_addr),
      .hit        (hit),
      .spr_id     (spr_id),
      .valid_out  (valid_out)
   );

   // Reference model: shadows as plain arrays, frame offset = frame index * stride.
   function automatic void model_reset();
      m_ticks = 0;
      for (int i = 0; i < N_SPR; i++) begin
         m_en[i] = 0; m_hp[i] = 0; m_vp[i] = 0; m_w[i] = 0; m_h[i] = 0;
         m_base[i] = 0; m_stride[i] = 0; m_nf[i] = 0; m_idx[i] = 0;
      end
   endfunction

   function automatic void model_tick();
      m_ticks++;
      for (int i = 0; i < N_SPR; i++) begin
         if (!m_en[i] || m_nf[i] <= 1) m_idx[i] = 0;
         else if (m_ticks % FRAME_DIV == 0) m_idx[i] = (m_idx[i] + 1) % m_nf[i];
         m_en[i] = cfg_en[i]; m_hp[i] = cfg_hp[i]; m_vp[i] = cfg_vp[i];
         m_w[i] = cfg_w[i]; m_h[i] = cfg_h[i]; m_base[i] = cfg_base[i];
         m_stride[i] = cfg_stride[i]; m_nf[i] = cfg_nf[i];
      end
   endfunction

   function automatic exp_t model_pix(int h, int v, bit vld);
      exp_t   e;
      longint raw;
      e = '0;
      e.vld = vld;
      for (int i = 0; i < N_SPR; i++) begin
         if (vld && !e.hit && m_en[i] && h >= m_hp[i] && h < m_hp[i] + m_w[i] &&
             v >= m_vp[i] && v < m_vp[i] + m_h[i]) begin
            raw = longint'(m_base[i]) + (longint'(m_idx[i]) * m_stride[i]) % 131072 +
                  (h - m_hp[i]) + longint'(m_w[i]) * (v - m_vp[i]);
`ifdef ADDR_WRAP_EN
            e.hit = 1'b1; e.id = 3'(i); e.addr = 17'(raw % longint'(MEM_DEPTH));
`else
            if (raw < longint'(MEM_DEPTH)) begin
               e.hit = 1'b1; e.id = 3'(i); e.addr = 17'(raw);
            end
`endif
         end
      end
      return e;
   endfunction

   task automatic check(input string name, input exp_t e);
      n_cmp++;
      if (hit !== e.hit || spr_id !== e.id || pixel_addr !== e.addr || valid_out !== e.vld) begin
         n_bad++;
         $display("FAIL %s: got hit=%0b id=%0d addr=%0d vld=%0b, want hit=%0b id=%0d addr=%0d vld=%0b",
                  name, hit, spr_id, pixel_addr, valid_out, e.hit, e.id, e.addr, e.vld);
      end
   endtask

   function automatic exp_t mk(bit h, int id, int addr, bit vld);
      exp_t e;
      e.hit = h; e.id = 3'(id); e.addr = 17'(addr); e.vld = vld;
      return e;
   endfunction

   task automatic clear_cfg();
      for (int i = 0; i < N_SPR; i++) begin
         cfg_en[i] = 0; cfg_hp[i] = 0; cfg_vp[i] = 0; cfg_w[i] = 0; cfg_h[i] = 0;
         cfg_base[i] = 0; cfg_stride[i] = 0; cfg_nf[i] = 0;
      end
   endtask

   task automatic set_spr(int i, bit en, int hp, int vp, int w, int h, int base, int str, int nf);
      cfg_en[i] = en; cfg_hp[i] = hp; cfg_vp[i] = vp; cfg_w[i] = w; cfg_h[i] = h;
      cfg_base[i] = base; cfg_stride[i] = str; cfg_nf[i] = nf;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic do_tick();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      model_tick();
   endtask

   task automatic push_pixel(int h, int v, bit vld);
      h_cnt = CNT_W'(h); v_cnt = CNT_W'(v); valid_in = vld; pix_en = 1'b1;
      repeat (3) @(negedge clk);
      pix_en = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [8];
      int   offs [6];
      exp_t dl [3];
      int   h, v, s;

      tbl[0] = '{h:105, v:52, vld:1, hit:1, id:0, addr:69};
      tbl[1] = '{h:131, v:50, vld:1, hit:1, id:0, addr:31};
      tbl[2] = '{h:132, v:50, vld:1, hit:0, id:0, addr:0};
      tbl[3] = '{h:99,  v:50, vld:1, hit:0, id:0, addr:0};
      tbl[4] = '{h:100, v:81, vld:1, hit:1, id:0, addr:992};
      tbl[5] = '{h:100, v:82, vld:1, hit:0, id:0, addr:0};
      tbl[6] = '{h:105, v:52, vld:0, hit:0, id:0, addr:0};
      tbl[7] = '{h:131, v:81, vld:1, hit:1, id:0, addr:1023};
      offs = '{0, 1024, 1024, 2048, 2048, 0};

      clear_cfg();
      model_reset();
      do_reset();
      check("reset", mk(0, 0, 0, 0));

      set_spr(0, 1, 100, 50, 32, 32, 0, 0, 0);
      push_pixel(105, 52, 1);
      check("pre_tick", mk(0, 0, 0, 1));
      do_tick();
      for (int k = 0; k < 8; k++) begin
         push_pixel(tbl[k].h, tbl[k].v, tbl[k].vld);
         check($sformatf("tbl%0d", k), mk(tbl[k].hit, int'(tbl[k].id), int'(tbl[k].addr),
                                         tbl[k].vld));
      end

      set_spr(2, 1, 110, 55, 20, 20, 5000, 0, 0);
      do_tick();
      push_pixel(120, 60, 1);
      check("overlap", mk(1, 0, 340, 1));
      cfg_en[0] = 0;
      push_pixel(120, 60, 1);
      check("no_tear", mk(1, 0, 340, 1));
      do_tick();
      push_pixel(120, 60, 1);
      check("ovl_dis0", mk(1, 2, 5110, 1));
      cfg_base[2] = 9000;
      push_pixel(120, 60, 1);
      check("base_no_tick", mk(1, 2, 5110, 1));
      do_tick();
      push_pixel(120, 60, 1);
      check("base_tick", mk(1, 2, 9110, 1));
      h_cnt = '0; valid_in = 1'b0;
      repeat (3) @(negedge clk);
      check("hold", mk(1, 2, 9110, 1));

      clear_cfg();
      do_reset();
      set_spr(0, 1, 100, 50, 32, 32, 0, 1024, 3);
      for (int k = 0; k < 6; k++) begin
         do_tick();
         push_pixel(105, 52, 1);
         check($sformatf("anim%0d", k + 1), mk(1, 0, 69 + offs[k], 1));
      end

      set_spr(0, 1, 100, 50, 32, 32, 76790, 0, 0);
      do_tick();
      push_pixel(105, 50, 1);
      check("below_depth", mk(1, 0, 76795, 1));
      push_pixel(115, 50, 1);
`ifdef ADDR_WRAP_EN
      check("wrap", mk(1, 0, 5, 1));
`else
      check("over_depth", mk(0, 0, 0, 1));
`endif

      push_pixel(105, 50, 1);
      pix_en = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_rst", mk(0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_lat2", mk(0, 0, 0, 0));
      @(negedge clk);
      check("rst_no_shadow", mk(0, 0, 0, 1));
      pix_en = 1'b0;
      do_tick();
      push_pixel(105, 50, 1);
      check("rst_then_tick", mk(1, 0, 76795, 1));

      // Random phase: animation parameters fixed per run, geometry reshuffled now and then.
      do_reset();
      for (int i = 0; i < N_SPR; i++) begin
         set_spr(i, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 700)),
                 int'($urandom_range(0, 450)), int'($urandom_range(0, 100)),
                 int'($urandom_range(0, 100)), int'($urandom_range(0, 79000)),
                 int'($urandom_range(0, 4000)), int'($urandom_range(0, 5)));
      end
      do_tick();
      do_tick();
      for (int k = 0; k < 3; k++) dl[k] = '0;
      for (int c = 0; c < 3000; c++) begin
         check("rand", dl[2]);
         if (c % 600 == 599) begin
            for (int i = 0; i < N_SPR; i++) begin
               cfg_hp[i] = int'($urandom_range(0, 700));
               cfg_vp[i] = int'($urandom_range(0, 450));
               cfg_w[i] = int'($urandom_range(0, 100));
               cfg_h[i] = int'($urandom_range(0, 100));
               cfg_base[i] = int'($urandom_range(0, 79000));
            end
         end
         s = int'($urandom_range(0, N_SPR - 1));
         h = cfg_hp[s] + int'($urandom_range(0, 4 + cfg_w[s])) - 2;
         v = cfg_vp[s] + int'($urandom_range(0, 4 + cfg_h[s])) - 2;
         if (h < 0) h = 0;
         if (h > 1023) h = 1023;
         if (v < 0) v = 0;
         if (v > 1023) v = 1023;
         h_cnt = CNT_W'(h);
         v_cnt = CNT_W'(v);
         valid_in = ($urandom_range(0, 9) != 0);
         pix_en = ($urandom_range(0, 9) < 7);
         frame_tick = ($urandom_range(0, 99) == 0);
         if (pix_en) begin
            dl[2] = dl[1];
            dl[1] = dl[0];
            dl[0] = model_pix(h, v, valid_in);
         end
         if (frame_tick) model_tick();
         @(negedge clk);
      end
      pix_en = 1'b0;
      frame_tick = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
